// File: rtl/decoder_seq_cc_if.sv
// Bus between the ROM-fetch/datapath side and the 4004-style sequencing decoder.
// The decoder connects through the slave modport; the fetch/datapath side uses master.
interface decoder_seq_cc_if #(
  parameter int DATA_W = 4,
  parameter int BANK_W = 3
);
  logic              stepEn;
  logic [7:0]        instrIn;
  logic              carryFromAlu;
  logic              zeroFromAlu;
  logic              testPin;
  logic [DATA_W-1:0] accIn;

  logic [2:0]        cycle;
  logic [3:0]        opr;
  logic [3:0]        opa;
  logic              secondWord;
  logic              aluEnable;
  logic [3:0]        aluOp;
  logic [3:0]        aluSubOp;
  logic              accWe;
  logic              regWe;
  logic              ramWe;
  logic              ramRe;
  logic              ioWe;
  logic              ioRe;
  logic              pairWe;
  logic [7:0]        pairDin;
  logic              pcLoad;
  logic              stackPush;
  logic              stackPop;
  logic              carryFlag;
  logic              zeroFlag;
  logic              ccTrue;
  logic [BANK_W-1:0] bankSel;

  modport master (
    output stepEn, instrIn, carryFromAlu, zeroFromAlu, testPin, accIn,
    input  cycle, opr, opa, secondWord, aluEnable, aluOp, aluSubOp,
           accWe, regWe, ramWe, ramRe, ioWe, ioRe, pairWe, pairDin,
           pcLoad, stackPush, stackPop, carryFlag, zeroFlag, ccTrue, bankSel
  );

  modport slave (
    input  stepEn, instrIn, carryFromAlu, zeroFromAlu, testPin, accIn,
    output cycle, opr, opa, secondWord, aluEnable, aluOp, aluSubOp,
           accWe, regWe, ramWe, ramRe, ioWe, ioRe, pairWe, pairDin,
           pcLoad, stackPush, stackPop, carryFlag, zeroFlag, ccTrue, bankSel
  );
endinterface

// File: rtl/decoder_seq_cc.sv
// 4004-style instruction decoder owning the 8-phase machine cycle (A1..X3), two-word tracking and JCN condition code.
// Optional macro TEST_SYNC_EN: run testPin through a 2-flop synchroniser before the condition code.
module decoder_seq_cc #(
  parameter int DATA_W = 4,
  parameter int CYCLES = 8,
  parameter int BANK_W = 3
) (
  input logic clk,
  input logic rst,
  decoder_seq_cc_if.slave bus
);
  localparam logic [2:0] X3  = 3'(CYCLES - 1);
  localparam logic [2:0] PRE = 3'(CYCLES - 2);
  localparam logic [2:0] M2  = 3'd4;
  localparam logic [2:0] X1  = 3'd5;

  localparam logic [3:0] OP_JCN = 4'h1, OP_FIM = 4'h2, OP_JUN = 4'h4, OP_JMS = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6, OP_ISZ = 4'h7, OP_ADD = 4'h8, OP_SUB = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA, OP_XCH = 4'hB, OP_BBL = 4'hC, OP_LDM = 4'hD;
  localparam logic [3:0] OP_IO  = 4'hE, OP_ACC = 4'hF;

  typedef struct packed {
    logic acc_we, reg_we, ram_we, ram_re, io_we, io_re, pair_we, pc_load, push, pop;
  } strobe_t;

  logic [2:0]        cycle_q;
  logic [3:0]        opr_q, opa_q;
  logic [7:0]        pair_q;
  logic              sw_q, carry_q, zero_q, cc_q;
  logic              sw_n, carry_n, zero_n, cc_n;
  logic [BANK_W-1:0] bank_q, bank_n;
  strobe_t           st_n, st_q;
  logic              test_pin, cond;

  function automatic strobe_t first_strobes(input logic [3:0] op, input logic [3:0] arg);
    strobe_t s;
    s = '0;
    case (op)
      OP_INC, OP_ISZ:                 s.reg_we = 1'b1;
      OP_ADD, OP_SUB, OP_LD, OP_LDM:  s.acc_we = 1'b1;
      OP_XCH: begin s.acc_we = 1'b1; s.reg_we = 1'b1; end
      OP_BBL: begin s.acc_we = 1'b1; s.pop    = 1'b1; end
      OP_IO: case (arg)
        4'h0, 4'h4, 4'h5, 4'h6, 4'h7: s.ram_we = 1'b1;
        4'h1, 4'h2:                   s.io_we  = 1'b1;
        4'h3:                         ;
        4'hA:    begin s.io_re  = 1'b1; s.acc_we = 1'b1; end
        default: begin s.ram_re = 1'b1; s.acc_we = 1'b1; end
      endcase
      OP_ACC: case (arg)
        4'h1, 4'h3, 4'hA, 4'hD, 4'hE, 4'hF: ;
        default: s.acc_we = 1'b1;
      endcase
      default: ;
    endcase
    return s;
  endfunction

  // Operand-word strobes: only the branch/stack/pair actions of the owning instruction.
  function automatic strobe_t second_strobes(input logic [3:0] op, input logic cc, input logic zf);
    strobe_t s;
    s = '0;
    case (op)
      OP_JCN: s.pc_load = cc;
      OP_FIM: s.pair_we = 1'b1;
      OP_JUN: s.pc_load = 1'b1;
      OP_JMS: begin s.pc_load = 1'b1; s.push = 1'b1; end
      OP_ISZ: s.pc_load = ~zf;
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic alu_used(input logic [3:0] op, input logic [3:0] arg);
    case (op)
      OP_INC, OP_ADD, OP_SUB, OP_LD, OP_BBL, OP_LDM, OP_ACC: return 1'b1;
      OP_IO:   return (arg == 4'h8) || (arg == 4'hB);
      default: return 1'b0;
    endcase
  endfunction

`ifdef TEST_SYNC_EN
  logic test_s1, test_s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      test_s1 <= 1'b1;
      test_s2 <= 1'b1;
    end else begin
      test_s1 <= bus.testPin;
      test_s2 <= test_s1;
    end
  end
  assign test_pin = test_s2;
`else
  assign test_pin = bus.testPin;
`endif

  assign cond = (~test_pin & opa_q[0]) | (carry_q & opa_q[1]) |
                ((bus.accIn == {DATA_W{1'b0}}) & opa_q[2]);

  always_comb begin
    st_n = sw_q ? second_strobes(opr_q, cc_q, zero_q) : first_strobes(opr_q, opa_q);
  end

  // State committed on the X3 -> A1 edge; secondWord clears unless a first word starts a pair.
  always_comb begin
    carry_n = carry_q;
    zero_n  = zero_q;
    sw_n    = 1'b0;
    cc_n    = cc_q;
    bank_n  = bank_q;
    if (!sw_q) begin
      case (opr_q)
        OP_JCN: begin sw_n = 1'b1; cc_n = opa_q[3] ? ~cond : cond; end
        OP_FIM:         sw_n = ~opa_q[0];
        OP_JUN, OP_JMS: sw_n = 1'b1;
        OP_ISZ: begin sw_n = 1'b1; zero_n = bus.zeroFromAlu; end
        OP_INC, OP_ADD, OP_SUB: begin
          carry_n = bus.carryFromAlu;
          zero_n  = bus.zeroFromAlu;
        end
        OP_LD, OP_LDM: zero_n = bus.zeroFromAlu;
        OP_IO: if (opa_q == 4'h8 || opa_q == 4'hB) begin
          carry_n = bus.carryFromAlu;
          zero_n  = bus.zeroFromAlu;
        end
        OP_ACC: case (opa_q)
          4'h0: begin carry_n = 1'b0; zero_n = 1'b1; end
          4'h1: carry_n = 1'b0;
          4'h3: carry_n = ~carry_q;
          4'h4, 4'hC: zero_n = bus.zeroFromAlu;
          4'h7, 4'h9: begin carry_n = 1'b0; zero_n = bus.zeroFromAlu; end
          4'hA: carry_n = 1'b1;
          4'hD: bank_n = bus.accIn[BANK_W-1:0];
          4'hE, 4'hF: ;
          default: begin carry_n = bus.carryFromAlu; zero_n = bus.zeroFromAlu; end
        endcase
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= 3'd0;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      pair_q  <= 8'h00;
      sw_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cc_q    <= 1'b0;
      bank_q  <= '0;
      st_q    <= '0;
    end else begin
      st_q <= '0;
      if (bus.stepEn) begin
        cycle_q <= (cycle_q == X3) ? 3'd0 : cycle_q + 3'd1;
        if (cycle_q == M2) begin
          if (sw_q) pair_q <= bus.instrIn;
          else      {opr_q, opa_q} <= bus.instrIn;
        end
        if (cycle_q == PRE) st_q <= st_n;
        if (cycle_q == X3) begin
          sw_q    <= sw_n;
          carry_q <= carry_n;
          zero_q  <= zero_n;
          cc_q    <= cc_n;
          bank_q  <= bank_n;
        end
      end
    end
  end

  assign bus.cycle      = cycle_q;
  assign bus.opr        = opr_q;
  assign bus.opa        = opa_q;
  assign bus.aluOp      = opr_q;
  assign bus.aluSubOp   = opa_q;
  assign bus.secondWord = sw_q;
  assign bus.aluEnable  = ~sw_q & (cycle_q >= X1) & alu_used(opr_q, opa_q);
  assign bus.accWe      = st_q.acc_we;
  assign bus.regWe      = st_q.reg_we;
  assign bus.ramWe      = st_q.ram_we;
  assign bus.ramRe      = st_q.ram_re;
  assign bus.ioWe       = st_q.io_we;
  assign bus.ioRe       = st_q.io_re;
  assign bus.pairWe     = st_q.pair_we;
  assign bus.pairDin    = pair_q;
  assign bus.pcLoad     = st_q.pc_load;
  assign bus.stackPush  = st_q.push;
  assign bus.stackPop   = st_q.pop;
  assign bus.carryFlag  = carry_q;
  assign bus.zeroFlag   = zero_q;
  assign bus.ccTrue     = cc_q;
  assign bus.bankSel    = bank_q;
endmodule

// File: tb/tb_decoder_seq_cc.sv
// Directed bench for decoder_seq_cc: expected strobe patterns are queued per instruction and popped by a strobe monitor.
`timescale 1ns/1ps
module tb_decoder_seq_cc;
  localparam int DATA_W = 4;
  localparam int BANK_W = 3;
  localparam logic [9:0] S_ACC = 10'h200, S_REG = 10'h100, S_RAMR = 10'h040;
  localparam logic [9:0] S_PAIR = 10'h008, S_PC = 10'h004, S_PUSH = 10'h002, S_POP = 10'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_s;
  logic [9:0] strobes;

  decoder_seq_cc_if #(.DATA_W(DATA_W), .BANK_W(BANK_W)) bus ();

  decoder_seq_cc #(.DATA_W(DATA_W), .CYCLES(8), .BANK_W(BANK_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign strobes = {bus.accWe, bus.regWe, bus.ramWe, bus.ramRe, bus.ioWe, bus.ioRe,
                    bus.pairWe, bus.pcLoad, bus.stackPush, bus.stackPop};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [7:0] b, input int n);
    bus.instrIn = b;
    bus.stepEn  = 1'b1;
    repeat (n) tick();
  endtask

  task automatic word_toggle(input logic [7:0] b, input int n);
    bus.instrIn = b;
    for (int i = 0; i < n; i++) begin
      bus.stepEn = (i % 2 == 0);
      tick();
    end
    bus.stepEn = 1'b1;
  endtask

  // Every clk with any strobe high consumes one queued expectation, so a stretched pulse fails.
  always @(negedge clk) begin
    if (!rst && strobes != 10'd0) begin
      if (sb.size() == 0) check("unexpected_strobe", 16'(strobes), 16'd0);
      else begin
        exp_s = sb.pop_front();
        check("strobe", 16'(strobes), 16'(exp_s));
      end
    end
  end

  initial begin
    bus.stepEn = 1'b1; bus.instrIn = 8'h40; bus.carryFromAlu = 1'b0;
    bus.zeroFromAlu = 1'b0; bus.testPin = 1'b1; bus.accIn = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_cycle", 16'(bus.cycle), 16'd0);
    check("rst_sw", 16'(bus.secondWord), 16'd0);
    check("rst_strobes", 16'(strobes), 16'd0);
    check("rst_flags", 16'({bus.carryFlag, bus.zeroFlag, bus.ccTrue}), 16'd0);
    check("rst_bank", 16'(bus.bankSel), 16'd0);
    check("rst_pair", 16'(bus.pairDin), 16'd0);
    check("rst_opr_opa", 16'({bus.opr, bus.opa}), 16'd0);
    check("rst_alu_en", 16'(bus.aluEnable), 16'd0);
    rst = 1'b0;

    // Reset in the middle of a JUN operand word
    word(8'h40, 8);
    check("jun_sw", 16'(bus.secondWord), 16'd1);
    word(8'h12, 6);
    check("jun2_cycle6", 16'(bus.cycle), 16'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cycle", 16'(bus.cycle), 16'd0);
    check("abort_sw", 16'(bus.secondWord), 16'd0);
    check("abort_pc", 16'(bus.pcLoad), 16'd0);
    word(8'h00, 8);
    check("abort_pc_after", 16'(bus.pcLoad), 16'd0);

    // LDM 5, then ADD with carry out
    sb.push_back(S_ACC);
    word(8'hD5, 8);
    check("ldm_opr_opa", 16'({bus.opr, bus.opa}), 16'hD5);
    check("ldm_zero", 16'(bus.zeroFlag), 16'd0);
    bus.carryFromAlu = 1'b1;
    sb.push_back(S_ACC);
    word(8'h80, 7);
    check("add_x3_cycle", 16'(bus.cycle), 16'd7);
    check("add_accwe", 16'(bus.accWe), 16'd1);
    check("add_alu_en", 16'(bus.aluEnable), 16'd1);
    check("add_aluop", 16'({bus.aluOp, bus.aluSubOp}), 16'h80);
    check("add_carry_pre", 16'(bus.carryFlag), 16'd0);
    tick();
    check("add_carry", 16'(bus.carryFlag), 16'd1);
    check("add_zero", 16'(bus.zeroFlag), 16'd0);
    check("add_accwe_off", 16'(bus.accWe), 16'd0);
    bus.carryFromAlu = 1'b0;

    // JCN on acc==0, taken
    bus.accIn = 4'h0;
    word(8'h14, 8);
    check("jcn4_cc", 16'(bus.ccTrue), 16'd1);
    check("jcn4_sw", 16'(bus.secondWord), 16'd1);
    sb.push_back(S_PC);
    word(8'h3C, 8);
    check("jcn4_pair", 16'(bus.pairDin), 16'h3C);
    check("jcn4_opr_hold", 16'({bus.opr, bus.opa}), 16'h14);
    check("jcn4_sw_clr", 16'(bus.secondWord), 16'd0);
    check("jcn4_sb", 16'(sb.size()), 16'd0);

    // Inverted acc==0 test: not taken with acc=0, taken with acc=7
    word(8'h1C, 8);
    check("jcnC_cc0", 16'(bus.ccTrue), 16'd0);
    word(8'hAB, 8);
    check("jcnC_pair", 16'(bus.pairDin), 16'hAB);
    bus.accIn = 4'h7;
    word(8'h1C, 8);
    check("jcnC_cc1", 16'(bus.ccTrue), 16'd1);
    sb.push_back(S_PC);
    word(8'h11, 8);
    check("jcnC_sb", 16'(sb.size()), 16'd0);

    // FIM with stepEn toggling every clk
    word_toggle(8'h24, 5);
    check("fim_toggle_cycle", 16'(bus.cycle), 16'd3);
    word_toggle(8'h24, 10);
    check("fim_cycle_wrap", 16'(bus.cycle), 16'd0);
    check("fim_sw", 16'(bus.secondWord), 16'd1);
    sb.push_back(S_PAIR);
    word_toggle(8'hA5, 13);
    check("fim_x3_cycle", 16'(bus.cycle), 16'd7);
    check("fim_pairwe", 16'(bus.pairWe), 16'd1);
    bus.stepEn = 1'b0;
    tick();
    check("fim_hold_cycle", 16'(bus.cycle), 16'd7);
    check("fim_pairwe_1clk", 16'(bus.pairWe), 16'd0);
    bus.stepEn = 1'b1;
    tick();
    check("fim_pair", 16'(bus.pairDin), 16'hA5);
    check("fim_sw_clr", 16'(bus.secondWord), 16'd0);

    // DCL loads bank from acc without an acc write
    bus.accIn = 4'h6;
    word(8'hFD, 7);
    check("dcl_accwe", 16'(bus.accWe), 16'd0);
    tick();
    check("dcl_bank", 16'(bus.bankSel), 16'h6);

    // ISZ with zero result: no branch on operand word
    bus.zeroFromAlu = 1'b1;
    sb.push_back(S_REG);
    word(8'h70, 8);
    check("isz_zero", 16'(bus.zeroFlag), 16'd1);
    check("isz_sw", 16'(bus.secondWord), 16'd1);
    word(8'h00, 8);
    check("isz_sw_clr", 16'(bus.secondWord), 16'd0);
    check("isz_sb", 16'(sb.size()), 16'd0);
    bus.zeroFromAlu = 1'b0;

    // JMS, STC/CMC, RDM, BBL, SRC
    word(8'h50, 8);
    sb.push_back(S_PC | S_PUSH);
    word(8'h12, 8);
    word(8'hFA, 8);
    check("stc_carry", 16'(bus.carryFlag), 16'd1);
    word(8'hF3, 8);
    check("cmc_carry", 16'(bus.carryFlag), 16'd0);
    sb.push_back(S_RAMR | S_ACC);
    word(8'hE9, 8);
    sb.push_back(S_ACC | S_POP);
    word(8'hC0, 8);
    word(8'h21, 8);
    check("src_single", 16'(bus.secondWord), 16'd0);

    // Active-low TEST pin condition
    bus.testPin = 1'b0;
    word(8'h11, 8);
    check("jcn_test_cc", 16'(bus.ccTrue), 16'd1);
    sb.push_back(S_PC);
    word(8'h77, 8);
    bus.testPin = 1'b1;

    check("sb_empty", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/decoder_seq_cc.md
Name: decoder_seq_cc

Overview:
- Parametrised successor to the cycle-driven 4004 decoder.
- Owns the 8-phase machine-cycle counter (A1..X3) instead of taking cycle as an input.
- Tracks two-word instructions (JCN/FIM/JUN/JMS/ISZ), registers the condition-code decision, and issues branch/stack/pair strobes alongside the usual ALU/ACC/RAM/IO controls.
- Sits between ROM fetch and datapath (ALU, register file, PC/stack, RAM bank select).

Parameters:
DATA_W, 4, width of ACC/ALU data (accIn, zero test)
CYCLES, 8, machine-cycle phases per instruction; X3 = CYCLES-1, fetch sample phase M2 = 4
BANK_W, 3, width of DCL bank-select register

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stepEn  in  1  advance machine-cycle counter this clk
instrIn  in  8  ROM byte {OPR,OPA}, sampled at cycle M2 when stepEn
carryFromAlu  in  1  ALU carry/borrow result
zeroFromAlu  in  1  ALU result==0
testPin  in  1  external TEST input, active-low sense
accIn  in  DATA_W  current accumulator
cycle  out  3  current phase 0..CYCLES-1
opr, opa  out  4 each  latched instruction nibbles
secondWord  out  1  current fetch is operand word of a two-word instruction
aluEnable  out  1  ALU active
aluOp, aluSubOp  out  4 each  = opr / opa of the executing first word
accWe, regWe, ramWe, ramRe, ioWe, ioRe  out  1 each  one-clk write/read strobes
pairWe  out  1  FIM pair write; pairDin out 8 operand byte
pcLoad, stackPush, stackPop  out  1 each  branch / JMS / BBL strobes
carryFlag, zeroFlag  out  1 each  condition flags
ccTrue  out  1  registered JCN condition
bankSel  out  BANK_W  DCL bank register

Behaviour:
- Reset (clk edge with rst=1): cycle=0, opr=opa=0, secondWord=0, all strobes=0, aluEnable=0, flags=0, ccTrue=0, bankSel=0, pairDin=0. Overrides stepEn; aborts any two-word sequence mid-flight.
- Counter: on stepEn, cycle increments and wraps CYCLES-1 -> 0. Without stepEn it holds.
- Sampling: at cycle==4 with stepEn, instrIn latched.
  - secondWord=0: latch into opr/opa.
  - secondWord=1: latch into pairDin only; opr/opa hold.
- Strobes: registered, high for exactly one clk, on the first clk where cycle==X3 (asserted on the edge entering X3). Held stepEn low does not stretch them.
- Flags and secondWord update only on the X3->0 edge (stepEn high at X3).
- aluEnable: high during X1..X3 (cycle>=5) for opr in {6,8,9,A,C,D,F}, and for E with opa in {8,B}.
- First-word X3 actions:
  - INC: regWe; carry and zero flags from ALU.
  - ADD/SUB: accWe; carry and zero flags from ALU.
  - LD/LDM: accWe; zero flag from ALU.
  - XCH: accWe and regWe.
  - BBL: accWe and stackPop.
  - E group: WRM/WR0-3 -> ramWe; WMP/WRR -> ioWe; RDM/RD0-3/SBM/ADM -> ramRe and accWe (SBM/ADM also update flags); RDR -> ioRe and accWe; WPM -> none.
  - F group: per 4004 semantics. DCL: bankSel<=accIn[BANK_W-1:0], no accWe.
- Condition code (JCN first-word X3): c = (~testPin&opa[0]) | (carryFlag&opa[1]) | ((accIn=={DATA_W{0}})&opa[2]); ccTrue <= opa[3] ? ~c : c.
- Two-word instructions: JCN, FIM (opr=2, opa[0]=0), JUN, JMS, ISZ.
  - secondWord set at first-word X3; cleared at second-word X3.
  - ISZ first word: regWe; zeroFlag <= zeroFromAlu.
  - Second-word X3: JCN pcLoad=ccTrue; JUN pcLoad; JMS pcLoad and stackPush; FIM pairWe; ISZ pcLoad=~zeroFlag.
  - No other strobes during a second word.
- SRC (opr=2, opa[0]=1), FIN, JIN: single word, no strobes.
- Simultaneous flag write and CMC at X3: CMC uses the pre-edge carryFlag.

Optional Feature:
TEST_SYNC_EN:
- Defined: testPin passes through a 2-flop synchroniser (reset to 1); the condition code uses the synchronised value, adding 2 clk latency.
- Undefined: testPin is used directly.

Test Plan:
- rst mid-JUN second word (cycle=6) -> next clk cycle=0, secondWord=0, pcLoad never asserted.
- LDM 0x5 then ADD with carryFromAlu=1, zeroFromAlu=0 -> accWe 1 clk at X3, carryFlag=1, zeroFlag=0 after X3.
- JCN opa=0x4 with accIn=0, then operand 0x3C -> ccTrue=1, pcLoad pulses at second-word X3, pairDin=0x3C.
- JCN opa=0xC with accIn=0 -> ccTrue=0, no pcLoad; same with accIn=0x7 -> pcLoad=1.
- FIM 0x24 then 0xA5 -> pairWe 1 clk, pairDin=0xA5; stepEn toggling 50% -> cycle advances only on enabled clks, strobes stay 1 clk.
- accIn=0x6, DCL (0xFD) -> bankSel=3'b110, accWe=0; ISZ with zeroFromAlu=1 -> no pcLoad on second word.
